// File: rtl/ofm_pool_pkg.sv
// ----------------------------------------------------------------------------
// ofm_pool_pkg
//   Shared constants and types for the 2x2 / stride-1 max-pool stage that sits
//   behind the 7x7-IFM / 3x3-weight convolution block.
//   - DW, IN_W, IN_H : input word width and 5x5 OFM geometry
//   - OUT_W, OUT_H   : pooled map geometry (4x4)
//   - COL_W, ROW_W   : raster counter widths
//   - word_t, pool_rsp_t, max2()
// ----------------------------------------------------------------------------
package ofm_pool_pkg;

   localparam int DW    = 36;
   localparam int IN_W  = 5;
   localparam int IN_H  = 5;
   localparam int OUT_W = IN_W - 1;
   localparam int OUT_H = IN_H - 1;
   localparam int COL_W = $clog2(IN_W);
   localparam int ROW_W = $clog2(IN_H);

   typedef logic [DW-1:0] word_t;

   // Registered output bundle of the pool stage.
   typedef struct packed {
      logic  vld;
      logic  done;
      word_t data;
   } pool_rsp_t;

   // Unsigned full-width compare; on a tie either operand is the same value.
   function automatic word_t max2(input word_t a, input word_t b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pool_line_buf.sv
// ----------------------------------------------------------------------------
// pool_line_buf
//   One-row line buffer for the max-pool stage. DEPTH x WIDTH register array
//   with a single port indexed by idx: rd_data is the stored (old) entry,
//   combinationally, and wr_data replaces it on the same rising edge when
//   wr_en is set, giving read-before-write behaviour. Resets to all zero.
//
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   wr_en    in   write wr_data to entry idx this cycle
//   idx      in   entry index (column)
//   wr_data  in   new entry value
//   rd_data  out  current value of entry idx (before this cycle's write)
// ----------------------------------------------------------------------------
module pool_line_buf #(
   parameter int DEPTH = 5,
   parameter int WIDTH = 36,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] idx,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data
);

   logic [DEPTH-1:0][WIDTH-1:0] mem;

   assign rd_data = mem[idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem <= '0;
      end else if (wr_en) begin
         mem[idx] <= wr_data;
      end
   end

endmodule

// File: rtl/ofm_maxpool2x2.sv
// ----------------------------------------------------------------------------
// ofm_maxpool2x2
//   2x2 max pooling, stride 1, over the serial 5x5 OFM stream of the conv
//   block. A one-row line buffer supplies the sample directly above the
//   current one; top_prev / left_prev hold the previous column of the window,
//   so each accepted sample at row>=1, col>=1 closes one 2x2 window. The
//   window maximum is registered, giving a fixed 1-cycle latency and a 4x4
//   pooled map (16 words) per frame in raster order.
//
//   clk        in   clock, all state on rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   In_OFM valid this cycle (conv block's out_valid)
//   In_OFM     in   DW-bit unsigned sample, raster order
//   out_valid  out  Out_Pool valid this cycle
//   Out_Pool   out  pooled maximum, zero when out_valid is low
//   frame_done out  pulse with the last pooled word of a frame
// ----------------------------------------------------------------------------
module ofm_maxpool2x2
   import ofm_pool_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [DW-1:0] In_OFM,
   output logic          out_valid,
   output logic [DW-1:0] Out_Pool,
   output logic          frame_done
);

   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic             last_col;
   logic             last_row;

   word_t     up;
   word_t     top_prev;
   word_t     left_prev;
   word_t     max_top;
   word_t     max_bot;
   word_t     win_max;
   logic      emit;
   pool_rsp_t rsp_d;
   pool_rsp_t rsp_q;

   assign last_col = (col == COL_W'(IN_W - 1));
   assign last_row = (row == ROW_W'(IN_H - 1));

   // -------------------------------------------------------------------------
   // Raster position of the sample being accepted; advances only on in_valid,
   // so gaps freeze the frame position. End of frame wraps both to 0, so the
   // next accepted sample is row 0 of the following frame.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col <= '0;
         row <= '0;
      end else if (in_valid) begin
         if (last_col) begin
            col <= '0;
            row <= last_row ? '0 : row + ROW_W'(1);
         end else begin
            col <= col + COL_W'(1);
         end
      end
   end

   // Line buffer: up is the previous row's sample in this column, read before
   // the current sample overwrites it.
   pool_line_buf #(
      .DEPTH (IN_W),
      .WIDTH (DW),
      .IDX_W (COL_W)
   ) u_line_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (in_valid),
      .idx     (col),
      .wr_data (In_OFM),
      .rd_data (up)
   );

   // Left column of the window. At col 0 these carry the previous row's tail,
   // but no output is produced at col 0 so that value is never consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         top_prev  <= '0;
         left_prev <= '0;
      end else if (in_valid) begin
         top_prev  <= up;
         left_prev <= In_OFM;
      end
   end

   // 4-input max tree over the 2x2 window.
   assign max_top = max2(top_prev, up);
   assign max_bot = max2(left_prev, In_OFM);
   assign win_max = max2(max_top, max_bot);

   // Row 0 and col 0 only prime the window. This also keeps stale line-buffer
   // contents from a previous frame out of the result.
   assign emit = in_valid && (row != '0) && (col != '0);

   always_comb begin
      rsp_d      = '0;
      rsp_d.vld  = emit;
      rsp_d.done = emit && last_row && last_col;
      rsp_d.data = emit ? win_max : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_q <= '0;
      end else begin
         rsp_q <= rsp_d;
      end
   end

   assign out_valid  = rsp_q.vld;
   assign frame_done = rsp_q.done;
   assign Out_Pool   = rsp_q.data;

endmodule

// File: tb/tb_ofm_maxpool2x2.sv
// ----------------------------------------------------------------------------
// tb_ofm_maxpool2x2
//   Drives frames into ofm_maxpool2x2 and compares every cycle against a
//   frame-array model: for sample index k of a frame, r=k/5, c=k%5, and when
//   r,c >= 1 the expected result is the max of samples k-6, k-5, k-1, k,
//   due one cycle later, with frame_done on k=24.
// ----------------------------------------------------------------------------
module tb_ofm_maxpool2x2;

   localparam int W  = 5;
   localparam int H  = 5;
   localparam int N  = W * H;
   localparam logic [35:0] ALL1 = 36'hF_FFFF_FFFF;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [35:0] In_OFM;
   logic        out_valid;
   logic [35:0] Out_Pool;
   logic        frame_done;

   ofm_maxpool2x2 dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .In_OFM     (In_OFM),
      .out_valid  (out_valid),
      .Out_Pool   (Out_Pool),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model state
   logic [35:0] fr [N];
   logic [35:0] src [N];
   int          k;
   logic        exp_v;
   logic [35:0] exp_d;
   logic        exp_done;
   int          obs_cnt;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [35:0] mx(input logic [35:0] a, input logic [35:0] b);
      return (a > b) ? a : b;
   endfunction

   task automatic check_out();
      chk("out_valid", 64'(out_valid), 64'(exp_v));
      chk("Out_Pool", 64'(Out_Pool), 64'(exp_d));
      chk("frame_done", 64'(frame_done), 64'(exp_done));
      if (out_valid) obs_cnt++;
   endtask

   // One clock: check what the previous edge produced, then present new input
   // and record what the next edge must produce.
   task automatic step(input bit v, input logic [35:0] d);
      int r, c;
      @(negedge clk);
      check_out();
      in_valid = v;
      In_OFM   = v ? d : {4'($urandom), $urandom};
      exp_v    = 1'b0;
      exp_d    = '0;
      exp_done = 1'b0;
      if (v) begin
         fr[k] = d;
         r = k / W;
         c = k % W;
         if (r >= 1 && c >= 1) begin
            exp_v    = 1'b1;
            exp_d    = mx(mx(fr[k-W-1], fr[k-W]), mx(fr[k-1], fr[k]));
            exp_done = (k == N - 1);
         end
         k = (k + 1) % N;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      check_out();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      exp_v    = 1'b0;
      exp_d    = '0;
      exp_done = 1'b0;
      k        = 0;
      #1;
      check_out();
      @(negedge clk);
      check_out();
      rst_n   = 1'b1;
      obs_cnt = 0;
   endtask

   // gap_len < 0: random gap of 0..3 cycles after each sample.
   task automatic send_frame(input int gap_every, input int gap_len);
      for (int i = 0; i < N; i++) begin
         step(1'b1, src[i]);
         if (gap_len < 0) begin
            repeat ($urandom_range(3, 0)) step(1'b0, '0);
         end else if (gap_every > 0 && (i % gap_every) == gap_every - 1) begin
            repeat (gap_len) step(1'b0, '0);
         end
      end
   endtask

   task automatic flush_and_count(input int want);
      repeat (2) step(1'b0, '0);
      chk("outputs_per_run", 64'(obs_cnt), 64'(want));
      obs_cnt = 0;
   endtask

   task automatic load_asc();
      for (int i = 0; i < N; i++) src[i] = 36'(i);
   endtask

   task automatic load_desc();
      for (int i = 0; i < N; i++) src[i] = 36'(N - 1 - i);
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      In_OFM   = '0;
      k        = 0;
      exp_v    = 1'b0;
      exp_d    = '0;
      exp_done = 1'b0;
      obs_cnt  = 0;
      for (int i = 0; i < N; i++) fr[i] = '0;

      do_reset();

      // Ascending, contiguous
      load_asc();
      send_frame(0, 0);
      flush_and_count(16);

      // Descending
      load_desc();
      send_frame(0, 0);
      flush_and_count(16);

      // Single full-scale sample at (2,2)
      for (int i = 0; i < N; i++) src[i] = '0;
      src[12] = ALL1;
      send_frame(0, 0);
      flush_and_count(16);

      // Ascending with 3-cycle gap after every 4th sample
      load_asc();
      send_frame(4, 3);
      flush_and_count(16);

      // Back-to-back ascending then descending, no idle between
      load_asc();
      send_frame(0, 0);
      load_desc();
      send_frame(0, 0);
      flush_and_count(32);

      // Abort after 13 samples, then a fresh ascending frame
      load_asc();
      for (int i = 0; i < 13; i++) step(1'b1, src[i]);
      do_reset();
      send_frame(0, 0);
      flush_and_count(16);

      // Random full-width frames with random gaps
      for (int f = 0; f < 6; f++) begin
         for (int i = 0; i < N; i++) src[i] = {4'($urandom), $urandom};
         send_frame(0, -1);
         flush_and_count(16);
      end

      // Small value range to force ties, back-to-back
      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < N; i++) src[i] = 36'($urandom_range(3, 0));
         send_frame(0, (f % 2 == 0) ? 0 : -1);
      end
      flush_and_count(64);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
